// File: rtl/periph_arb_pkg.sv
// Shared types and constants for the two-master peripheral bus arbiter.
package periph_arb_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBus  = 2'd1,
    StResp = 2'd2
  } arb_state_e;

  localparam logic M_CPU = 1'b0;
  localparam logic M_DMA = 1'b1;

  localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

endpackage

// File: rtl/periph_arb_timeout.sv
// BUS-state watchdog: cleared by i_load, advances on i_count, flags the final allowed cycle.
module periph_arb_timeout #(
  parameter int unsigned Cycles = 255
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_count,
  output logic o_expire
);

  localparam logic [15:0] Last = 16'(Cycles - 1);

  logic [15:0] cnt_q;

  // o_expire is high during the last permitted BUS cycle, so the abort lands on its closing edge.
  assign o_expire = i_count && (cnt_q == Last);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt_q <= '0;
    end else if (i_load) begin
      cnt_q <= '0;
    end else if (i_count && !o_expire) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: rtl/periph_arbiter.sv
// Round-robin arbiter giving a CPU (m0) and a DMA (m1) master access to one peripheral bus.
// Optional BUS-state timeout abort is built when PERIPH_ARB_TIMEOUT_EN is defined.
module periph_arbiter
  import periph_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_m0_req,
  input  logic        i_m0_we,
  input  logic [15:0] i_m0_addr,
  input  logic [15:0] i_m0_wdata,
  output logic        o_m0_gnt,
  output logic        o_m0_done,
  output logic [15:0] o_m0_rdata,
  output logic        o_m0_err,
  input  logic        i_m1_req,
  input  logic        i_m1_we,
  input  logic [15:0] i_m1_addr,
  input  logic [15:0] i_m1_wdata,
  output logic        o_m1_gnt,
  output logic        o_m1_done,
  output logic [15:0] o_m1_rdata,
  output logic        o_m1_err,
  output logic [15:0] o_addr,
  output logic [15:0] o_wdata,
  output logic        o_sel,
  output logic        o_we,
  output logic        o_re,
  input  logic [15:0] i_rdata,
  input  logic        i_rdy
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("periph_arbiter: TIMEOUT_CYCLES must be 1..65535");
  end

  arb_state_e  state_q, state_d;
  logic        owner_q, owner_d;
  logic        rr_q, rr_d;
  logic        we_q, we_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  logic grant, pick, in_bus, in_resp, expired, abort, finish;

  assign in_bus  = (state_q == StBus);
  assign in_resp = (state_q == StResp);
  assign grant   = i_m0_req | i_m1_req;
  // Pointer only matters on contention; a lone requester always wins.
  assign pick    = (i_m0_req && i_m1_req) ? rr_q : (i_m1_req ? M_DMA : M_CPU);
  assign abort   = in_bus && !i_rdy && expired;
  assign finish  = in_bus && i_rdy;

`ifdef PERIPH_ARB_TIMEOUT_EN
  logic err_q;

  periph_arb_timeout #(
    .Cycles(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (state_q == StIdle),
    .i_count (in_bus),
    .o_expire(expired)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      err_q <= 1'b0;
    end else if (in_bus) begin
      err_q <= abort;
    end
  end

  assign o_m0_err = o_m0_done & err_q;
  assign o_m1_err = o_m1_done & err_q;
`else
  assign expired  = 1'b0;
  assign o_m0_err = 1'b0;
  assign o_m1_err = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    unique case (state_q)
      StIdle: begin
        if (grant) begin
          state_d = StBus;
          owner_d = pick;
          we_d    = pick ? i_m1_we : i_m0_we;
          addr_d  = pick ? i_m1_addr : i_m0_addr;
          wdata_d = pick ? i_m1_wdata : i_m0_wdata;
        end
      end
      StBus: begin
        if (finish || abort) begin
          state_d = StResp;
          rr_d    = ~owner_q;
          // Reads capture the bus; an abort forces zero; a completed write leaves rdata alone.
          if (abort || !we_q) begin
            if (owner_q == M_DMA) begin
              rdata1_d = abort ? 16'h0000 : i_rdata;
            end else begin
              rdata0_d = abort ? 16'h0000 : i_rdata;
            end
          end
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= StIdle;
      owner_q  <= M_CPU;
      rr_q     <= M_CPU;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign o_sel      = in_bus;
  assign o_we       = in_bus & we_q;
  assign o_re       = in_bus & ~we_q;
  assign o_addr     = in_bus ? addr_q : 16'h0000;
  assign o_wdata    = in_bus ? wdata_q : 16'h0000;
  assign o_m0_gnt   = (in_bus | in_resp) && (owner_q == M_CPU);
  assign o_m1_gnt   = (in_bus | in_resp) && (owner_q == M_DMA);
  assign o_m0_done  = in_resp && (owner_q == M_CPU);
  assign o_m1_done  = in_resp && (owner_q == M_DMA);
  assign o_m0_rdata = rdata0_q;
  assign o_m1_rdata = rdata1_q;

endmodule

// File: tb/tb_periph_arbiter.sv
// Directed self-checking bench for periph_arbiter: vector table plus multi-cycle sequences.
module tb_periph_arbiter;

`ifdef PERIPH_ARB_TIMEOUT_EN
  localparam int unsigned ToCycles = 4;
  localparam int StallCycles = 2;
`else
  localparam int unsigned ToCycles = 255;
  localparam int StallCycles = 7;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0, rdy = 0;
  logic [15:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, rdata = 0;
  logic        m0_gnt, m0_done, m0_err, m1_gnt, m1_done, m1_err;
  logic [15:0] m0_rdata, m1_rdata, addr, wdata;
  logic        sel, we, re;

  int total = 0;
  int bad = 0;

  periph_arbiter #(
    .TIMEOUT_CYCLES(ToCycles)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_m0_req  (m0_req),
    .i_m0_we   (m0_we),
    .i_m0_addr (m0_addr),
    .i_m0_wdata(m0_wdata),
    .o_m0_gnt  (m0_gnt),
    .o_m0_done (m0_done),
    .o_m0_rdata(m0_rdata),
    .o_m0_err  (m0_err),
    .i_m1_req  (m1_req),
    .i_m1_we   (m1_we),
    .i_m1_addr (m1_addr),
    .i_m1_wdata(m1_wdata),
    .o_m1_gnt  (m1_gnt),
    .o_m1_done (m1_done),
    .o_m1_rdata(m1_rdata),
    .o_m1_err  (m1_err),
    .o_addr    (addr),
    .o_wdata   (wdata),
    .o_sel     (sel),
    .o_we      (we),
    .o_re      (re),
    .i_rdata   (rdata),
    .i_rdy     (rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        m0r, m0w;
    logic [15:0] m0a, m0d;
    logic        m1r, m1w;
    logic [15:0] m1a, m1d;
    logic        rdy;
    logic [15:0] rd;
    logic [6:0]  ef;   // {sel, we, re, gnt0, gnt1, done0, done1}
    logic [15:0] ea, ed, er0, er1;
  } vec_t;

  vec_t vecs[12];

  function automatic vec_t mk(input logic m0r, input logic m0w, input logic [15:0] m0a,
                              input logic [15:0] m0d, input logic m1r, input logic m1w,
                              input logic [15:0] m1a, input logic [15:0] m1d, input logic r,
                              input logic [15:0] rd, input logic [6:0] ef, input logic [15:0] ea,
                              input logic [15:0] ed, input logic [15:0] er0,
                              input logic [15:0] er1);
    vec_t v;
    v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
    v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
    v.rdy = r; v.rd = rd; v.ef = ef; v.ea = ea; v.ed = ed; v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check({name, " flags"}, 32'({sel, we, re, m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err}),
          32'h0);
    check({name, " addr"}, 32'(addr), 32'h0);
    check({name, " wdata"}, 32'(wdata), 32'h0);
    check({name, " rdata0"}, 32'(m0_rdata), 32'h0);
    check({name, " rdata1"}, 32'(m1_rdata), 32'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_req = 0; m1_req = 0; rdy = 0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic m0_read(input logic [15:0] a, input logic [15:0] d, input string name);
    m0_req = 1; m0_we = 0; m0_addr = a; rdy = 1; rdata = d;
    tick();
    check({name, " sel"}, 32'({sel, re, addr}), 32'({1'b1, 1'b1, a}));
    tick();
    check({name, " done"}, 32'({m0_done, m0_err, m0_rdata}), 32'({1'b1, 1'b0, d}));
    m0_req = 0; rdy = 0;
    tick();
  endtask

  initial begin
    int seq[6];
    int n, c0, c1, two_gnt, stable, dones, bus_cycles;
    bit seen;

    vecs[0]  = mk(1, 0, 16'h3002, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF,
                  7'b1011000, 16'h3002, 16'h0000, 16'h0000, 16'h0000);
    vecs[1]  = mk(1, 0, 16'h3002, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 16'hBEEF,
                  7'b0001010, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000);
    vecs[2]  = mk(0, 0, 16'h3002, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,
                  7'b0000000, 16'h0000, 16'h0000, 16'hBEEF, 16'h0000);
    vecs[3]  = mk(1, 1, 16'h0010, 16'h1111, 1, 0, 16'h0020, 16'h0000, 1, 16'h2222,
                  7'b1010100, 16'h0020, 16'h0000, 16'hBEEF, 16'h0000);
    vecs[4]  = mk(1, 1, 16'h0010, 16'h1111, 1, 0, 16'h0020, 16'h0000, 1, 16'h2222,
                  7'b0000101, 16'h0000, 16'h0000, 16'hBEEF, 16'h2222);
    vecs[5]  = mk(1, 1, 16'h0010, 16'h1111, 1, 1, 16'h0030, 16'h3030, 1, 16'h3333,
                  7'b0000000, 16'h0000, 16'h0000, 16'hBEEF, 16'h2222);
    vecs[6]  = mk(1, 1, 16'h0010, 16'h1111, 1, 1, 16'h0030, 16'h3030, 1, 16'h3333,
                  7'b1101000, 16'h0010, 16'h1111, 16'hBEEF, 16'h2222);
    vecs[7]  = mk(1, 1, 16'h0010, 16'h1111, 1, 1, 16'h0030, 16'h3030, 1, 16'h3333,
                  7'b0001010, 16'h0000, 16'h0000, 16'hBEEF, 16'h2222);
    vecs[8]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0030, 16'h3030, 1, 16'h3333,
                  7'b0000000, 16'h0000, 16'h0000, 16'hBEEF, 16'h2222);
    vecs[9]  = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0030, 16'h3030, 1, 16'h3333,
                  7'b1100100, 16'h0030, 16'h3030, 16'hBEEF, 16'h2222);
    vecs[10] = mk(0, 0, 16'h0000, 16'h0000, 1, 1, 16'h0030, 16'h3030, 1, 16'h3333,
                  7'b0000101, 16'h0000, 16'h0000, 16'hBEEF, 16'h2222);
    vecs[11] = mk(0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 16'h0000,
                  7'b0000000, 16'h0000, 16'h0000, 16'hBEEF, 16'h2222);

    // Reset state
    do_reset();
    check_zero("reset");

    // Vector table: single read, contention, pointer rotation, writes
    foreach (vecs[i]) begin
      m0_req = vecs[i].m0r; m0_we = vecs[i].m0w; m0_addr = vecs[i].m0a; m0_wdata = vecs[i].m0d;
      m1_req = vecs[i].m1r; m1_we = vecs[i].m1w; m1_addr = vecs[i].m1a; m1_wdata = vecs[i].m1d;
      rdy = vecs[i].rdy; rdata = vecs[i].rd;
      tick();
      check($sformatf("vec%0d flags", i),
            32'({sel, we, re, m0_gnt, m1_gnt, m0_done, m1_done}), 32'(vecs[i].ef));
      check($sformatf("vec%0d addr", i), 32'(addr), 32'(vecs[i].ea));
      check($sformatf("vec%0d wdata", i), 32'(wdata), 32'(vecs[i].ed));
      check($sformatf("vec%0d rdata0", i), 32'(m0_rdata), 32'(vecs[i].er0));
      check($sformatf("vec%0d rdata1", i), 32'(m1_rdata), 32'(vecs[i].er1));
    end

    // Both masters held for three transactions each: grants alternate from m0
    do_reset();
    m0_req = 1; m0_we = 1; m0_addr = 16'h0100; m0_wdata = 16'h00A0;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0200; rdy = 1; rdata = 16'h1357;
    n = 0; c0 = 0; c1 = 0; two_gnt = 0;
    for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
      tick();
      if (m0_gnt && m1_gnt) two_gnt++;
      if (m0_done) begin
        seq[n] = 0; n++; c0++;
        if (c0 == 3) m0_req = 0;
      end
      if (m1_done && n < 6) begin
        seq[n] = 1; n++; c1++;
        if (c1 == 3) m1_req = 0;
      end
    end
    check("rr completions", 32'(n), 32'd6);
    for (int i = 0; i < 6; i++) check($sformatf("rr order%0d", i), 32'(seq[i]), 32'(i % 2));
    check("rr two gnts", 32'(two_gnt), 32'd0);
    check("rr rdata1", 32'(m1_rdata), 32'h1357);
    m0_req = 0; m1_req = 0; rdy = 0;
    tick();

    // m1 write with stalled ready; request dropped mid-transaction
    m1_req = 1; m1_we = 1; m1_addr = 16'h0102; m1_wdata = 16'hA5A5; rdy = 0; rdata = 16'hFFFF;
    tick();
    stable = 0; dones = 0;
    for (int i = 0; i <= StallCycles; i++) begin
      if ({sel, we, re, m1_gnt, addr, wdata} == {1'b1, 1'b1, 1'b0, 1'b1, 16'h0102, 16'hA5A5})
        stable++;
      if (m1_done) dones++;
      if (i == 1) m1_req = 0;
      if (i == StallCycles) rdy = 1;
      tick();
    end
    check("stall stable", 32'(stable), 32'(StallCycles + 1));
    check("stall early done", 32'(dones), 32'd0);
    check("stall done", 32'({m1_done, m1_err, sel, m1_rdata}), 32'({3'b100, 16'h1357}));
    rdy = 0;
    tick();
    check("stall single pulse", 32'({m1_done, m1_gnt}), 32'd0);

    // Timeout abort (or indefinite wait without the timeout feature)
    m0_read(16'h5000, 16'h600D, "pre read");
    m0_req = 1; m0_we = 0; m0_addr = 16'h4000; rdy = 0; rdata = 16'hFFFF;
    tick();
    bus_cycles = 0; seen = 0;
`ifdef PERIPH_ARB_TIMEOUT_EN
    for (int i = 0; i < 20 && !seen; i++) begin
      if (sel) bus_cycles++;
      if (m0_done) seen = 1;
      else tick();
    end
    check("to bus cycles", 32'(bus_cycles), 32'(ToCycles));
    check("to abort", 32'({seen, m0_err, m0_rdata}), 32'({2'b11, 16'h0000}));
    m0_req = 0;
    tick();
`else
    for (int i = 0; i < 20; i++) begin
      if (sel && !m0_done && !m0_err) bus_cycles++;
      tick();
    end
    check("no-to wait", 32'(bus_cycles), 32'd20);
    rdy = 1; rdata = 16'h0042;
    tick();
    check("no-to done", 32'({m0_done, m0_err, m0_rdata}), 32'({2'b10, 16'h0042}));
    m0_req = 0; rdy = 0;
    tick();
`endif
    m0_read(16'h5002, 16'h7777, "post read");

    // Asynchronous reset while in BUS
    m0_req = 1; m0_we = 0; m0_addr = 16'h6000; rdy = 0;
    tick();
    check("pre-rst bus", 32'({sel, m0_gnt}), 32'b11);
    #2;
    rst = 1;
    #1;
    check_zero("async rst");
    m0_req = 0;
    dones = 0;
    for (int i = 0; i < 2; i++) begin
      tick();
      if (m0_done || m1_done) dones++;
    end
    check("rst no done", 32'(dones), 32'd0);
    rst = 0;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0ABC; rdy = 1; rdata = 16'h0BAD;
    tick();
    check("post-rst grant", 32'({m1_gnt, m0_gnt, sel, addr}), 32'({3'b101, 16'h0ABC}));
    tick();
    check("post-rst done", 32'({m1_done, m1_rdata}), 32'({1'b1, 16'h0BAD}));
    m1_req = 0; rdy = 0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
